// File: rtl/vga_pixel_gen.sv
// vga_pixel_gen: pixel source for the VGA timing controller.
// Composes a 32x32 tile background read from an external synchronous ROM and
// overlays up to NUM_SPRITES solid square sprites. Sprite registers are
// written into a shadow bank that is copied to the active bank at the last
// visible pixel of each frame, so a frame never mixes two sprite states.
// Fixed two-cycle latency from row/col/rdn to pix_out.
//
// Ports:
//   vga_clk, clr        pixel clock, synchronous active-high reset
//   row_addr, col_addr  visible pixel address from the timing controller
//   rdn                 active-low pixel-read strobe
//   tile_addr           combinational tile-ROM address (0 while rdn=1)
//   tile_data           tile-ROM colour, valid one cycle after tile_addr
//   spr_we..spr_color   shadow sprite-register write port
//   pix_out             registered 12-bit pixel (rrrr_gggg_bbbb)
//   frame_commit        one-cycle pulse when the active bank loads

module vga_pixel_gen #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPR_SIZE    = 16,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic        vga_clk,
    input  logic        clr,
    input  logic [9:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [8:0]  tile_addr,
    input  logic [11:0] tile_data,
    input  logic        spr_we,
    input  logic [2:0]  spr_idx,
    input  logic        spr_en,
    input  logic [9:0]  spr_x,
    input  logic [9:0]  spr_y,
    input  logic [11:0] spr_color,
    output logic [11:0] pix_out,
    output logic        frame_commit
);

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned CMP_W     = COORD_W + 1;
    localparam int unsigned COLOR_W   = 12;
    localparam int unsigned TILE_AW   = 9;
    localparam int unsigned TILES_ROW = 20;
    localparam int unsigned LAST_ROW  = 479;
    localparam int unsigned LAST_COL  = 639;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } spr_t;

    spr_t shadow_q [NUM_SPRITES];
    spr_t active_q [NUM_SPRITES];

    logic               rdn_d1_q;
    logic               spr_hit_d1_q;
    logic [COLOR_W-1:0] spr_col_d1_q;
    logic [COLOR_W-1:0] pix_q;
    logic [COLOR_W-1:0] pix_d;
    logic               frame_commit_q;

    logic [NUM_SPRITES-1:0] hit_c;
    logic                   any_hit_c;
    logic [COLOR_W-1:0]     hit_col_c;
    logic                   commit_c;
    logic [CMP_W-1:0]       row_w;
    logic [CMP_W-1:0]       col_w;

    // Tile index: 20 tiles per row, each tile 32x32 pixels.
    always_comb begin
        tile_addr = '0;
        if (!rdn) begin
            tile_addr = TILE_AW'(row_addr[8:5]) * TILE_AW'(TILES_ROW)
                      + TILE_AW'(col_addr[9:5]);
        end
    end

    // Per-slot hit test in 11 bits so x+SPR_SIZE cannot wrap back to 0.
    always_comb begin
        hit_c = '0;
        row_w = {1'b0, row_addr};
        col_w = {1'b0, col_addr};
        for (int i = 0; i < int'(NUM_SPRITES); i++) begin
            hit_c[i] = active_q[i].en && !rdn
                    && (col_w >= {1'b0, active_q[i].x})
                    && (col_w <  {1'b0, active_q[i].x} + CMP_W'(SPR_SIZE))
                    && (row_w >= {1'b0, active_q[i].y})
                    && (row_w <  {1'b0, active_q[i].y} + CMP_W'(SPR_SIZE));
        end
    end

    // Priority encode: scanning downward lets the lowest slot win.
    always_comb begin
        any_hit_c = 1'b0;
        hit_col_c = '0;
        for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                any_hit_c = 1'b1;
                hit_col_c = active_q[i].color;
            end
        end
    end

    // Last visible pixel of the frame triggers the bank swap.
    assign commit_c = !rdn
                   && (row_addr == COORD_W'(LAST_ROW))
                   && (col_addr == COORD_W'(LAST_COL));

    // Stage 2 colour select; tile_data lines up with the stage-1 registers.
    always_comb begin
        pix_d = '0;
        if (!rdn_d1_q) begin
            if (spr_hit_d1_q) begin
                pix_d = spr_col_d1_q;
            end else if (tile_data == '0) begin
                pix_d = BG_COLOR;
            end else begin
                pix_d = tile_data;
            end
        end
    end

    // Pipeline, shadow bank and active bank.
    always_ff @(posedge vga_clk) begin
        if (clr) begin
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            rdn_d1_q       <= 1'b1;
            spr_hit_d1_q   <= 1'b0;
            spr_col_d1_q   <= '0;
            pix_q          <= '0;
            frame_commit_q <= 1'b0;
        end else begin
            rdn_d1_q       <= rdn;
            spr_hit_d1_q   <= any_hit_c;
            spr_col_d1_q   <= hit_col_c;
            pix_q          <= pix_d;
            frame_commit_q <= commit_c;
            // Active takes the pre-write shadow value when both happen at once.
            if (commit_c) begin
                for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            // Slots at or above NUM_SPRITES never match, so such writes drop.
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                if (spr_we && (spr_idx == 3'(i))) begin
                    shadow_q[i] <= {spr_en, spr_x, spr_y, spr_color};
                end
            end
        end
    end

    assign pix_out      = pix_q;
    assign frame_commit = frame_commit_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Testbench for vga_pixel_gen: directed pixel addresses with scoreboarded
// pixel and frame_commit expectations, plus a synchronous tile-ROM model.

module tb_vga_pixel_gen;

    localparam logic [11:0] BG = 12'hABC;

    logic        vga_clk = 1'b0;
    logic        clr = 1'b1;
    logic [9:0]  row_addr = '0;
    logic [9:0]  col_addr = '0;
    logic        rdn = 1'b1;
    logic [8:0]  tile_addr;
    logic [11:0] tile_data = '0;
    logic        spr_we = 1'b0;
    logic [2:0]  spr_idx = '0;
    logic        spr_en = 1'b0;
    logic [9:0]  spr_x = '0;
    logic [9:0]  spr_y = '0;
    logic [11:0] spr_color = '0;
    logic [11:0] pix_out;
    logic        frame_commit;

    vga_pixel_gen #(
        .NUM_SPRITES(4),
        .SPR_SIZE   (16),
        .BG_COLOR   (BG)
    ) dut (
        .vga_clk     (vga_clk),
        .clr         (clr),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .rdn         (rdn),
        .tile_addr   (tile_addr),
        .tile_data   (tile_data),
        .spr_we      (spr_we),
        .spr_idx     (spr_idx),
        .spr_en      (spr_en),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_color   (spr_color),
        .pix_out     (pix_out),
        .frame_commit(frame_commit)
    );

    always #20 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] exp;
        string       nm;
    } exp_t;

    exp_t pq[$];
    exp_t fq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Staged sprite write / reset, applied by the next drive() call.
    logic        wr_pend = 1'b0;
    logic        clr_pend = 1'b0;
    logic [2:0]  w_idx = '0;
    logic        w_en = 1'b0;
    logic [9:0]  w_x = '0;
    logic [9:0]  w_y = '0;
    logic [11:0] w_col = '0;

    function automatic logic [11:0] rom(input int a);
        if (a % 50 == 7) return 12'h000;
        return 12'(a * 37 + 1);
    endfunction

    function automatic logic [11:0] tc(input int r, input int c);
        logic [11:0] t;
        t = rom((r / 32) * 20 + c / 32);
        return (t == 12'h000) ? BG : t;
    endfunction

    function automatic logic [11:0] exp_ta(input int r, input int c, input logic rd);
        if (rd) return 12'h000;
        return 12'(((r >> 5) & 15) * 20 + ((c >> 5) & 31));
    endfunction

    // Synchronous tile ROM: data one cycle after the address.
    always @(posedge vga_clk) tile_data <= rom(int'(tile_addr));

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare each due expectation against the DUT outputs.
    always @(negedge vga_clk) begin : monitor
        exp_t e;
        while (pq.size() != 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            chk(e.nm, pix_out, e.exp);
        end
        while (fq.size() != 0 && fq[0].due <= cyc) begin
            e = fq.pop_front();
            chk(e.nm, {11'd0, frame_commit}, e.exp);
        end
    end

    task automatic drive(input int r, input int c, input logic rd,
                         input logic [11:0] exp, input string nm);
        logic is_commit;
        @(negedge vga_clk);
        row_addr  = 10'(r);
        col_addr  = 10'(c);
        rdn       = rd;
        clr       = clr_pend;
        clr_pend  = 1'b0;
        spr_we    = wr_pend;
        spr_idx   = w_idx;
        spr_en    = w_en;
        spr_x     = w_x;
        spr_y     = w_y;
        spr_color = w_col;
        wr_pend   = 1'b0;
        is_commit = !rd && (r == 479) && (c == 639) && !clr;
        pq.push_back('{cyc + 2, exp, nm});
        fq.push_back('{cyc + 1, is_commit ? 12'd1 : 12'd0, "frame_commit"});
        #1 chk("tile_addr", {3'd0, tile_addr}, exp_ta(r, c, rd));
    endtask

    task automatic px(input int r, input int c, input logic [11:0] exp, input string nm);
        drive(r, c, 1'b0, exp, nm);
    endtask

    task automatic idle();
        drive(0, 0, 1'b1, 12'h000, "blank");
    endtask

    task automatic stage_wr(input int idx, input logic en, input int x, input int y,
                            input logic [11:0] col);
        wr_pend = 1'b1;
        w_idx   = 3'(idx);
        w_en    = en;
        w_x     = 10'(x);
        w_y     = 10'(y);
        w_col   = col;
    endtask

    task automatic wr(input int idx, input logic en, input int x, input int y,
                      input logic [11:0] col);
        stage_wr(idx, en, x, y, col);
        idle();
    endtask

    task automatic commit(input logic [11:0] exp);
        px(479, 639, exp, "commit_px");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(negedge vga_clk);
        chk("reset_pix", pix_out, 12'h000);
        chk("reset_fc", {11'd0, frame_commit}, 12'h000);

        // Background only, sprites all disabled.
        idle();
        idle();
        px(0, 0, tc(0, 0), "bg_0_0");
        px(0, 33, rom(1), "bg_rom1");
        px(0, 224, BG, "bg_transparent");
        px(100, 300, tc(100, 300), "bg_100_300");
        drive(470, 635, 1'b1, 12'h000, "blank_rdn");
        commit(rom(299));
        idle();

        // Slot 1 red box at (100,50).
        wr(1, 1'b1, 100, 50, 12'hF00);
        px(50, 100, tc(50, 100), "spr1_pre_commit");
        commit(rom(299));
        px(50, 100, 12'hF00, "spr1_tl");
        px(65, 115, 12'hF00, "spr1_br");
        px(50, 99, tc(50, 99), "spr1_left_out");
        px(50, 116, tc(50, 116), "spr1_right_out");
        px(49, 100, tc(49, 100), "spr1_above");
        px(66, 100, tc(66, 100), "spr1_below");

        // Overlap: slot 0 beats slot 2.
        wr(0, 1'b1, 200, 200, 12'h0F0);
        wr(2, 1'b1, 200, 200, 12'h00F);
        commit(rom(299));
        px(210, 210, 12'h0F0, "overlap_lo");
        wr(0, 1'b0, 200, 200, 12'h0F0);
        px(210, 210, 12'h0F0, "disable_pending");
        commit(rom(299));
        px(210, 210, 12'h00F, "overlap_hi");

        // Mid-frame write must not show until the next commit.
        wr(0, 1'b1, 300, 300, 12'h0F0);
        commit(rom(299));
        px(300, 300, 12'h0F0, "spr0_x300");
        stage_wr(0, 1'b1, 10, 300, 12'h0F0);
        px(240, 0, tc(240, 0), "midframe_wr");
        px(300, 300, 12'h0F0, "midframe_old_x");
        px(300, 10, tc(300, 10), "midframe_new_hidden");
        commit(rom(299));
        px(300, 10, 12'h0F0, "after_commit_new_x");
        px(300, 300, tc(300, 300), "after_commit_old_gone");
        stage_wr(0, 1'b1, 400, 300, 12'h0F0);
        commit(rom(299));
        px(300, 10, 12'h0F0, "commit_wr_old");
        px(300, 400, tc(300, 400), "commit_wr_hidden");
        commit(rom(299));
        px(300, 400, 12'h0F0, "commit_wr_new");
        px(300, 10, tc(300, 10), "commit_wr_old_gone");

        // Edge clipping at the bottom-right corner.
        wr(3, 1'b1, 630, 470, 12'hFFF);
        commit(rom(299));
        px(470, 630, 12'hFFF, "clip_tl");
        px(469, 630, tc(469, 630), "clip_above");
        px(470, 629, tc(470, 629), "clip_left");
        px(0, 0, tc(0, 0), "clip_nowrap_00");
        px(5, 5, tc(5, 5), "clip_nowrap_55");
        px(470, 0, tc(470, 0), "clip_nowrap_col");
        px(0, 630, tc(0, 630), "clip_nowrap_row");
        drive(475, 635, 1'b1, 12'h000, "clip_rdn_blank");
        commit(12'hFFF);

        // Reset mid-frame at row 100 with sprites active.
        wr(0, 1'b1, 150, 100, 12'h0F0);
        commit(12'hFFF);
        px(100, 150, 12'h0F0, "pre_reset_spr");
        px(100, 151, 12'h000, "pix_rst0");
        clr_pend = 1'b1;
        px(100, 152, 12'h000, "pix_rst1");
        px(100, 153, tc(100, 153), "post_reset_bg");
        px(100, 150, tc(100, 150), "post_reset_spr0_off");
        px(60, 110, tc(60, 110), "post_reset_spr1_off");
        px(475, 635, tc(475, 635), "post_reset_spr3_off");
        commit(rom(299));
        px(100, 150, tc(100, 150), "post_reset_commit_empty");
        wr(0, 1'b1, 150, 100, 12'h0F0);
        commit(rom(299));
        px(100, 150, 12'h0F0, "rewrite_spr0");
        px(60, 110, tc(60, 110), "rewrite_spr1_off");
        idle();
        idle();

        for (int k = 0; k < 10 && (pq.size() != 0 || fq.size() != 0); k++)
            @(negedge vga_clk);
        if (pq.size() != 0 || fq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", pq.size() + fq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
